// File: rtl/instr_encoder_if.sv
// Request/write handshake bundle for the RV32 instruction encoder.
// The slave side is the encoder; the master side is the producer/memory writer.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, fmt, opcode, rd, funct3,
        output rs1, rs2, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, funct3,
        input  rs1, rs2, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs fields into words and streams them to sequential memory addresses.
// Optional macro INSTR_ENCODER_IMM_CHECK_EN flags immediates that do not fit the chosen format.
module instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus,
    input  logic             restart,
    output logic             full,
    output logic             err
);
    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {
        LOAD,
        FULL
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              err_q;
    logic [31:0]       enc;
    logic              fmt_bad;
    logic              rng_bad;
    logic              accept;

    logic [31:0] imm;
    assign imm = bus.imm;

    assign bus.in_ready  = !restart && (state_q == LOAD)
                         && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign cnt_d         = cnt_q + 1'b1;

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign full          = (state_q == FULL);
    assign err           = err_q;

    // Pack the request fields into a 32-bit word for the selected format.
    always_comb begin
        enc     = NOP;
        fmt_bad = 1'b0;
        unique case (bus.fmt)
            FMT_R: enc = {bus.funct7, bus.rs2, bus.rs1,
                          bus.funct3, bus.rd, bus.opcode};
            FMT_I: enc = {imm[11:0], bus.rs1,
                          bus.funct3, bus.rd, bus.opcode};
            FMT_S: enc = {imm[11:5], bus.rs2, bus.rs1,
                          bus.funct3, imm[4:0], bus.opcode};
            FMT_B: enc = {imm[12], imm[10:5], bus.rs2, bus.rs1,
                          bus.funct3, imm[4:1], imm[11], bus.opcode};
            FMT_U: enc = {imm[31:12], bus.rd, bus.opcode};
            FMT_J: enc = {imm[20], imm[10:1], imm[11],
                          imm[19:12], bus.rd, bus.opcode};
            default: begin
                enc     = NOP;
                fmt_bad = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    // Flag immediates whose dropped upper bits are not a sign extension.
    always_comb begin
        rng_bad = 1'b0;
        unique case (bus.fmt)
            FMT_I, FMT_S: rng_bad = (|imm[31:11]) && !(&imm[31:11]);
            FMT_B: rng_bad = imm[0]
                           || ((|imm[31:12]) && !(&imm[31:12]));
            FMT_J: rng_bad = imm[0]
                           || ((|imm[31:20]) && !(&imm[31:20]));
            FMT_U: rng_bad = |imm[11:0];
            default: rng_bad = 1'b0;
        endcase
    end
`else
    assign rng_bad = 1'b0;
`endif

    // Load-sequence FSM, address counter, sticky error and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= BASE_ADDR;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
        end else begin
            if (restart) begin
                state_q <= LOAD;
                cnt_q   <= BASE_ADDR;
                err_q   <= 1'b0;
            end else if (accept) begin
                cnt_q <= cnt_d;
                // Counter wrapping back to its start means every word is used.
                if (cnt_d == BASE_ADDR) begin
                    state_q <= FULL;
                end
                if (fmt_bad || rng_bad) begin
                    err_q <= 1'b1;
                end
            end
            // A pending word is owned by the writer, so restart leaves it alone.
            if (accept) begin
                out_valid_q <= 1'b1;
                out_instr_q <= enc;
                out_addr_q  <= cnt_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
